// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 async-SRAM style bus: on-chip word array,
// configurable read latency, preload port. Optional counters under SRAM_RESPONDER_STATS_EN.
module sram_responder #(
  parameter int ADDR_W     = 20,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CE,
  input  logic                  UB,
  input  logic                  LB,
  input  logic                  OE,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     ADDR,
  inout  wire  [15:0]           Data,
  input  logic                  Load_En,
  input  logic [DEPTH_LOG2-1:0] Load_Addr,
  input  logic [15:0]           Load_Data,
  output logic                  Rd_Valid,
  output logic                  Busy
`ifdef SRAM_RESPONDER_STATS_EN
  ,
  output logic [15:0]           Rd_Count,
  output logic [15:0]           Wr_Count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, DRIVE} state_e;

  logic [15:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         out_q, out_d;
  logic                rd_valid_q, busy_q;
  logic                rd_req, wr_req, start_read, load_out;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  assign rd_req = !CE && WE && !OE;
  assign wr_req = !CE && !WE;
  assign wr_idx = ADDR[DEPTH_LOG2-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    start_read = 1'b0;
    load_out   = 1'b0;
    rd_idx     = addr_q[DEPTH_LOG2-1:0];
    case (state_q)
      IDLE: if (rd_req) start_read = 1'b1;
      READ_WAIT: begin
        if (!rd_req) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (ADDR != addr_q) begin
          start_read = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          state_d  = DRIVE;
          load_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRIVE: begin
        if (!rd_req) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (ADDR != addr_q) begin
          start_read = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    // A new read (from IDLE or an address change) restarts the latency count.
    if (start_read) begin
      addr_d = ADDR;
      rd_idx = ADDR[DEPTH_LOG2-1:0];
      if (READ_LAT == 1) begin
        state_d  = DRIVE;
        load_out = 1'b1;
      end else begin
        state_d = READ_WAIT;
        cnt_d   = 3'd1;
      end
    end
    // Array is sampled on DRIVE entry so a preceding write is always visible.
    out_d = load_out ? mem[rd_idx] : out_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      out_q      <= 16'h0000;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      rd_valid_q <= (state_d == DRIVE);
      busy_q     <= (state_d == READ_WAIT);
    end
  end

  // Storage is not reset; preload is last so it wins over a same-index bus write.
  always_ff @(posedge Clk) begin
    if (wr_req && !UB) mem[wr_idx][15:8] <= Data[15:8];
    if (wr_req && !LB) mem[wr_idx][7:0]  <= Data[7:0];
    if (Load_En)       mem[Load_Addr]    <= Load_Data;
  end

  assign Data     = (state_q == DRIVE && rd_req) ? out_q : 16'hzzzz;
  assign Rd_Valid = rd_valid_q;
  assign Busy     = busy_q;

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (load_out && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_req && (!UB || !LB) && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign Rd_Count = rd_cnt_q;
  assign Wr_Count = wr_cnt_q;
`endif

endmodule
